// File: rtl/toggle_event_receiver_pkg.sv
// ============================================================================
// toggle_event_receiver_pkg : shared receiver FSM states and sync-depth limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package toggle_event_receiver_pkg;

   typedef enum logic {
      ARM = 1'b0,
      RUN = 1'b1
   } rx_state_e;

   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned SYNC_STAGES_MAX = 4;

   // Wide enough to count up to SYNC_STAGES_MAX while arming
   localparam int unsigned ARM_CNT_W = $clog2(SYNC_STAGES_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/toggle_event_receiver_toggle_sync.sv
// ============================================================================
// toggle_sync : multi-flop synchronizer for a toggle line plus edge detector
// Revision: 1.0
// ============================================================================
`default_nettype none

module toggle_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic tog_i,
   input  logic detect_en_i,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // prev tracks the synchronized level even while detection is disabled
   assign edge_o = detect_en_i & (sync_q[SYNC_STAGES-1] != prev_q);

endmodule

`default_nettype wire

// File: rtl/toggle_event_receiver.sv
// ============================================================================
// toggle_event_receiver : toggle-link event decoder with pending-count handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module toggle_event_receiver
   import toggle_event_receiver_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PEND_W      = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tog_in,
   output logic              evt_pulse,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [PEND_W-1:0] pending,
   output logic [CNT_W-1:0]  total,
   output logic              overflow,
   input  logic              clr_ovf
);

   localparam logic [PEND_W-1:0]    PEND_MAX  = '1;
   localparam logic [ARM_CNT_W-1:0] ARM_LAST  = ARM_CNT_W'(SYNC_STAGES);

   rx_state_e            state_q;
   logic [ARM_CNT_W-1:0] arm_cnt_q;
   logic                 pulse_q;
   logic [PEND_W-1:0]    pending_q, pending_d;
   logic [CNT_W-1:0]     total_q, total_d;
   logic                 overflow_q, overflow_d;

   logic evt_edge;
   logic take;
   logic ovf_set;

   toggle_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk         (clk),
      .reset       (reset),
      .tog_i       (tog_in),
      .detect_en_i (state_q == RUN),
      .edge_o      (evt_edge)
   );

   assign evt_valid = (pending_q != '0);
   assign take      = evt_valid & evt_ready;
   // Simultaneous edge and take cancel out, so only a lone edge at max drops
   assign ovf_set   = evt_edge & ~take & (pending_q == PEND_MAX);

   always_comb begin
      pending_d  = pending_q;
      total_d    = total_q;
      overflow_d = ovf_set | (overflow_q & ~clr_ovf);
      if (evt_edge) begin
         total_d = total_q + 1'b1;
      end
      case ({evt_edge, take})
         2'b10: begin
            if (pending_q != PEND_MAX) begin
               pending_d = pending_q + 1'b1;
            end
         end
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ARM;
         arm_cnt_q  <= '0;
         pulse_q    <= 1'b0;
         pending_q  <= '0;
         total_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         pulse_q    <= evt_edge;
         pending_q  <= pending_d;
         total_q    <= total_d;
         overflow_q <= overflow_d;
         case (state_q)
            ARM: begin
               // Hold off detection until the chain and prev reflect tog_in
               arm_cnt_q <= arm_cnt_q + 1'b1;
               if (arm_cnt_q == ARM_LAST) begin
                  state_q <= RUN;
               end
            end
            RUN:     state_q <= RUN;
            default: state_q <= ARM;
         endcase
      end
   end

   assign evt_pulse = pulse_q;
   assign pending   = pending_q;
   assign total     = total_q;
   assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: doc/toggle_event_receiver.md
Name: toggle_event_receiver

Overview:
- Receive end of a toggle-encoded event link. The upstream sender flips one wire once per event.
- This block synchronizes that wire into clk and turns each transition, rising or falling, back into a single-cycle event pulse.
- Detected events are buffered as a pending count and handed to a consumer through a valid/ready handshake. A free-running event total and a sticky overflow flag are kept alongside.
- Sits at the boundary between any toggle-output source and the control logic consuming its events.

Parameters:
- SYNC_STAGES, 2, synchronizer depth in flops on tog_in; legal range 2..4.
- PEND_W, 4, width of the pending-event counter; max pending is 2^PEND_W-1.
- CNT_W, 16, width of the total-event counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- tog_in  input  1  toggle-encoded event line, asynchronous to clk
- evt_pulse  output  1  one-cycle pulse per detected transition
- evt_valid  output  1  high while pending count is nonzero
- evt_ready  input  1  consumer accepts one event when evt_valid and evt_ready are both high
- pending  output  PEND_W  events detected but not yet accepted
- total  output  CNT_W  events detected since reset; wraps
- overflow  output  1  sticky; an event was dropped because pending was full
- clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Reset is sampled on the rising edge of clk while reset==0. During reset and on the cycle it takes effect:
  - sync chain = 0, prev = 0, state = ARM, arm counter = 0
  - evt_pulse = 0, evt_valid = 0, pending = 0, total = 0, overflow = 0
- Synchronizer: SYNC_STAGES-flop chain on tog_in; the last stage is s.
- FSM, two states:
  - ARM: prev <= s every cycle; arm counter increments; no edge detection. Leave to RUN after SYNC_STAGES+1 cycles in ARM. Purpose: tog_in sitting at 1 through reset must not produce a false event.
  - RUN: edge = (s != prev); prev <= s. Stays in RUN until reset.
- Edge-to-pulse latency: a tog_in change that meets setup before edge k gives evt_pulse high on cycle k+SYNC_STAGES. evt_pulse is registered and high for exactly one cycle.
- total increments on every edge, whether or not the event is dropped. It wraps from 2^CNT_W-1 to 0 with no flag.
- Handshake: take = evt_valid & evt_ready. evt_valid = (pending != 0), driven from the registered pending value.
- Pending update per cycle:
  - edge only, pending < max: pending+1
  - edge only, pending == max: unchanged, overflow <= 1
  - take only: pending-1
  - edge and take together: unchanged. Never overflows, even at max.
  - neither: unchanged
- evt_ready while evt_valid==0 has no effect; pending never underflows.
- overflow: set and clr_ovf in the same cycle gives set (set wins). Otherwise clr_ovf clears it.
- Two tog_in transitions closer than one clk period may merge or be lost. The sender guarantees a minimum of 2 clk periods between toggles.
- Reset mid-operation discards pending events and returns to ARM regardless of tog_in level.

Decomposition:
- Shared package: FSM state typedef (ARM, RUN) and the SYNC_STAGES legal-range constants; the toggle sender reuses them.
- One sub-module, toggle_sync: parameterized SYNC_STAGES flop chain plus prev register and edge output.
- Counters, FSM and handshake stay in the top module.

Test Plan:
- Reset with tog_in held 1, release, no toggles for 20 cycles -> evt_pulse never high, pending=0, total=0.
- Sync latency: SYNC_STAGES=2, one toggle 0->1 after arming -> evt_pulse high exactly 2 cycles later for 1 cycle; pending=1, total=1, evt_valid=1.
- Drain: 3 toggles spaced 4 cycles apart with evt_ready=0, then evt_ready=1 -> pending goes 3,2,1,0 on consecutive cycles; evt_valid drops with pending=0.
- Full: PEND_W=2, evt_ready=0, 5 toggles -> pending saturates at 3, total=5, overflow=1. A clr_ovf pulse then gives overflow=0 and pending stays 3.
- Simultaneous edge and take at pending=3 (max) with PEND_W=2 -> pending stays 3, overflow stays 0, total increments.
- Wrap and reset: CNT_W=4, 17 toggles -> total=1. Assert reset with pending=2 -> pending=0, total=0, overflow=0, FSM back in ARM; no spurious pulse after release.
